// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the two-port BRAM arbiter: FSM encoding,
// default geometry and requester-id width.
package bram_port_arbiter_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int          DEF_DATA_W = 32;
  localparam int          DEF_ADDR_W = 19;
  localparam logic [31:0] DEF_DEPTH  = 32'h5_0000;
  localparam int          ID_W       = 1;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Delay line carrying {valid, requester id} for each accepted read so the
// response can be steered to its owner when the RAM data emerges.
module bram_rd_tag_pipe
  import bram_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id
);

  // One stage for the command register plus RD_LAT stages for the RAM.
  localparam int STAGES = RD_LAT + 1;

  logic [STAGES-1:0]           valid_q;
  logic [STAGES-1:0][ID_W-1:0] id_q;

  // Shift the read tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q[0] <= in_valid;
      id_q[0]    <= in_id;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_id    = id_q[STAGES-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with a
// built-in sweep that fills the whole RAM with a constant value.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int          DATA_W = DEF_DATA_W,
  parameter int          ADDR_W = DEF_ADDR_W,
  parameter logic [31:0] DEPTH  = DEF_DEPTH,
  parameter int          RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_data,
  output logic              clear_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_regce,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 32'd1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   prio_q, prio_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] clr_data_q, clr_data_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              done_q, done_d;

  logic              gnt_valid;
  logic [ID_W-1:0]   gnt_id;
  logic              rd_push;
  logic              tag_valid;
  logic [ID_W-1:0]   tag_id;

  // Arbitration, clear sequencing and next RAM command.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    clr_data_d = clr_data_q;
    en_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    done_d     = 1'b0;
    gnt_valid  = 1'b0;
    gnt_id     = '0;
    rd_push    = 1'b0;
    case (state_q)
      ARB: begin
        if (clear_start) begin
          // Clear wins over any request presented in the same cycle.
          state_d    = CLEAR;
          clr_data_d = clear_data;
          cnt_d      = '0;
        end else if (req0_valid && req1_valid) begin
          gnt_valid = 1'b1;
          gnt_id    = prio_q;
        end else if (req0_valid) begin
          gnt_valid = 1'b1;
          gnt_id    = ID_W'(0);
        end else if (req1_valid) begin
          gnt_valid = 1'b1;
          gnt_id    = ID_W'(1);
        end
        if (gnt_valid) begin
          prio_d  = ~gnt_id;
          en_d    = 1'b1;
          we_d    = (gnt_id == ID_W'(1)) ? req1_we    : req0_we;
          addr_d  = (gnt_id == ID_W'(1)) ? req1_addr  : req0_addr;
          din_d   = (gnt_id == ID_W'(1)) ? req1_wdata : req0_wdata;
          rd_push = !we_d;
        end
      end
      CLEAR: begin
        en_d   = 1'b1;
        we_d   = 1'b1;
        addr_d = cnt_q;
        din_d  = clr_data_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = ARB;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State, priority pointer, clear counter and registered RAM command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      prio_q     <= '0;
      cnt_q      <= '0;
      clr_data_q <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      clr_data_q <= clr_data_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      done_q     <= done_d;
    end
  end

  bram_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_push),
    .in_id    (gnt_id),
    .out_valid(tag_valid),
    .out_id   (tag_id)
  );

  // Ready is combinational from the grant; forced low while reset is held.
  assign req0_ready = !rst && gnt_valid && (gnt_id == ID_W'(0));
  assign req1_ready = !rst && gnt_valid && (gnt_id == ID_W'(1));

  assign rsp0_valid = tag_valid && (tag_id == ID_W'(0));
  assign rsp1_valid = tag_valid && (tag_id == ID_W'(1));
  assign rsp0_rdata = rsp0_valid ? ram_dout : '0;
  assign rsp1_rdata = rsp1_valid ? ram_dout : '0;

  assign clear_done = done_q;
  assign ram_en     = en_q;
  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_din    = din_q;
  assign ram_regce  = 1'b1;
  assign ram_rst    = rst;

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, which sets the RAM word width.
REQ-002 SHALL have parameter ADDR_W, default 19, which sets the RAM address width (depth 32'h5_0000).
REQ-003 SHALL have parameter DEPTH, default 32'h5_0000, which sets the number of words swept by a clear.
REQ-004 SHALL have parameter RD_LAT, default 2, which sets the RAM read latency (2 in HIGH_PERFORMANCE mode, 1 in LOW_LATENCY mode).
REQ-005 SHALL have ports clk (in, 1, the single clock) and rst (in, 1, asynchronous active-high reset).
REQ-006 SHALL have, for each requester N in {0,1}: reqN_valid (in, 1), reqN_we (in, 1), reqN_addr (in, ADDR_W), reqN_wdata (in, DATA_W) and reqN_ready (out, 1).
REQ-007 SHALL have, for each requester N in {0,1}: rspN_valid (out, 1) and rspN_rdata (out, DATA_W), carrying read data back to that requester.
REQ-008 SHALL have ports clear_start (in, 1), clear_data (in, DATA_W) and clear_done (out, 1, one-cycle pulse).
REQ-009 SHALL have RAM-side outputs ram_en, ram_we, ram_addr (ADDR_W), ram_din (DATA_W), ram_regce and ram_rst, plus the RAM-side input ram_dout (DATA_W).

Function
REQ-010 SHALL implement a two-state FSM with states ARB and CLEAR.
REQ-011 In ARB, SHALL assert reqN_ready combinationally only for the granted requester, granting at most one requester per cycle.
REQ-012 SHALL grant round-robin: a lone valid requester is granted; if both are valid, the requester not granted last is granted; the priority pointer updates only on a grant.
REQ-013 A request SHALL be accepted when valid&&ready; the requester SHALL hold its valid and payload stable until accepted.
REQ-014 SHALL register each accepted command so that ram_en=1 and ram_we, ram_addr and ram_din carry the command in the cycle after acceptance; otherwise ram_en=0 and ram_we=0.
REQ-015 SHALL track accepted reads in a {valid, id} shift register of depth RD_LAT+1.
REQ-016 For a read accepted in cycle T, SHALL assert rspN_valid for exactly one cycle at T+1+RD_LAT, with rspN_rdata=ram_dout.
REQ-017 Writes SHALL produce no response.
REQ-018 Back-to-back reads, one per cycle, SHALL be sustained, and responses SHALL return in acceptance order.
REQ-019 SHALL drive ram_regce=1 constantly and ram_rst=rst.
REQ-020 When clear_start=1 in ARB, SHALL grant nothing that cycle, enter CLEAR next cycle and latch clear_data; clear has priority over requests arriving in the same cycle.
REQ-021 In CLEAR, SHALL hold both reqN_ready low and issue one write per cycle, of the latched data, to addresses 0..DEPTH-1 in order.
REQ-022 After the write to address DEPTH-1 is issued, SHALL pulse clear_done for one cycle and return to ARB on the following cycle.
REQ-023 clear_start received while in CLEAR SHALL be ignored.
REQ-024 Reads still in flight on entry to CLEAR SHALL still complete with normal response timing.
REQ-025 The clear address counter SHALL be ADDR_W wide and SHALL NOT wrap past DEPTH-1.

Reset
REQ-026 Asserting rst SHALL put the FSM in ARB, point priority at requester 0, and clear the tag pipeline and clear counter.
REQ-027 While rst is asserted, all outputs SHALL be 0 except ram_regce=1 and ram_rst=1.
REQ-028 Reset mid-CLEAR SHALL abort the sweep without a clear_done pulse.
REQ-029 Reset SHALL drop in-flight responses, with no rspN_valid until new reads complete.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the default ADDR_W/DATA_W/DEPTH constants and the requester-id width.
REQ-031 The tag delay line SHALL be one sub-module, bram_rd_tag_pipe, parameterized by RD_LAT.

Verification
REQ-032 Scenario 1: req0 writes 0xDEADBEEF to addr 0x10, then reads addr 0x10 -> rsp0_valid exactly 3 cycles after read acceptance (RD_LAT=2) with rdata 0xDEADBEEF, and rsp1_valid stays 0.
REQ-033 Scenario 2: both requesters read continuously for 8 cycles -> grants alternate 0,1,0,1, with 4 responses each, in order, one per cycle.
REQ-034 Scenario 3: clear_start with clear_data 0 and DEPTH overridden to 16 -> 16 writes to addresses 0..15, ready low throughout, a single clear_done pulse, then readback returns 0 everywhere.
REQ-035 Scenario 4: read accepted, then clear_start next cycle -> the read's response still arrives at T+3 with its pre-clear value.
REQ-036 Scenario 5: rst asserted asynchronously mid-CLEAR at address 7 -> outputs go to reset values immediately, no clear_done pulse, and the FSM is in ARB after release.
REQ-037 Scenario 6: req1 alone valid for 3 reads -> granted every cycle, and the priority pointer does not starve req0 when req0 then asserts valid.
